// File: rtl/demux_pkg.sv
// Shared types and helpers for the stream demultiplexer.
// Contents: state_t (IDLE/LOCKED), RST_DATA fill value, clog2 helper.
package demux_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Value loaded into the data register on reset and after a drain.
    localparam int RST_DATA = 0;

    // Select width an instantiator should use for a given channel count.
    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/demux_out_slot.sv
// Single-entry registered output stage of the demultiplexer.
// Ports: clk, rst (sync, active high); load/load_dst/load_data/load_last
// write the slot; out_ready is the per-lane consumer ready vector;
// vld/dst/data/last expose the held beat; ready is the upstream ready.
module demux_out_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_CH  = 4,
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [SEL_W-1:0] load_dst,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_last,
    input  logic [N_CH-1:0]  out_ready,
    output logic             vld,
    output logic [SEL_W-1:0] dst,
    output logic [WIDTH-1:0] data,
    output logic             last,
    output logic             ready
);

    logic             vld_q;
    logic [SEL_W-1:0] dst_q;
    logic [WIDTH-1:0] data_q;
    logic             last_q;
    logic             lane_rdy;
    logic             drain;

    // Ready of the lane the held beat targets; explicit compare keeps
    // the lookup safe when N_CH is not a power of two.
    always_comb begin
        lane_rdy = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (dst_q == SEL_W'(k)) begin
                lane_rdy = out_ready[k];
            end
        end
    end

    assign drain = vld_q && lane_rdy;

    // The slot can take a new beat when empty or emptying this cycle.
    assign ready = !rst && (!vld_q || lane_rdy);

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            dst_q  <= '0;
            data_q <= WIDTH'(RST_DATA);
            last_q <= 1'b0;
        end else if (load) begin
            vld_q  <= 1'b1;
            dst_q  <= load_dst;
            data_q <= load_data;
            last_q <= load_last;
        end else if (drain) begin
            vld_q  <= 1'b0;
            data_q <= WIDTH'(RST_DATA);
            last_q <= 1'b0;
        end
    end

    assign vld  = vld_q;
    assign dst  = dst_q;
    assign data = data_q;
    assign last = last_q;

endmodule

// File: rtl/stream_demux.sv
// 1-to-N_CH valid/ready stream demultiplexer with packet-level select lock.
// Ports: clk, rst (sync, active high); in_data/in_sel/in_last/in_valid and
// in_ready upstream; out_data/out_last/out_valid/out_ready per lane;
// err_drop pulses when a beat targets a lane >= N_CH; cnt_clr/cnt are the
// per-lane delivered-beat counters, present only when DEMUX_CNT_EN is
// defined (otherwise cnt reads 0 and cnt_clr is ignored).
module stream_demux
    import demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_CH  = 4,
    parameter int SEL_W = 2,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      in_data,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic                  in_last,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [N_CH*WIDTH-1:0] out_data,
    output logic [N_CH-1:0]       out_last,
    output logic [N_CH-1:0]       out_valid,
    input  logic [N_CH-1:0]       out_ready,
    output logic                  err_drop,
    input  logic                  cnt_clr,
    output logic [N_CH*CNT_W-1:0] cnt
);

    localparam logic [SEL_W:0] NCH_X = (SEL_W+1)'(N_CH);

    state_t           state_q;
    logic [SEL_W-1:0] lock_sel_q;
    logic             err_drop_q;
    logic [SEL_W-1:0] eff_sel;
    logic             in_range;
    logic             accept;
    logic             load;

    logic             slot_vld;
    logic [SEL_W-1:0] slot_dst;
    logic [WIDTH-1:0] slot_data;
    logic             slot_last;

    // Once a packet has started, its remaining beats follow the lock.
    assign eff_sel  = (state_q == LOCKED) ? lock_sel_q : in_sel;
    assign in_range = {1'b0, eff_sel} < NCH_X;
    assign accept   = in_valid && in_ready;
    assign load     = accept && in_range;

    demux_out_slot #(
        .WIDTH (WIDTH),
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_dst  (eff_sel),
        .load_data (in_data),
        .load_last (in_last),
        .out_ready (out_ready),
        .vld       (slot_vld),
        .dst       (slot_dst),
        .data      (slot_data),
        .last      (slot_last),
        .ready     (in_ready)
    );

    // Out-of-range beats are swallowed but still advance the packet
    // FSM, so the whole packet drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            lock_sel_q <= '0;
            err_drop_q <= 1'b0;
        end else begin
            err_drop_q <= accept && !in_range;
            unique case (state_q)
                IDLE: begin
                    if (accept && !in_last) begin
                        lock_sel_q <= in_sel;
                        state_q    <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (accept && in_last) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign err_drop = err_drop_q;

    // Lane fan-out: only the addressed lane sees the held beat.
    always_comb begin
        out_valid = '0;
        out_last  = '0;
        out_data  = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (slot_vld && (slot_dst == SEL_W'(k))) begin
                out_valid[k]               = 1'b1;
                out_last[k]                = slot_last;
                out_data[k*WIDTH +: WIDTH] = slot_data;
            end
        end
    end

`ifdef DEMUX_CNT_EN
    for (genvar k = 0; k < N_CH; k++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q;

        // Clear wins over a same-cycle delivery; wrap is natural.
        always_ff @(posedge clk) begin
            if (rst || cnt_clr) begin
                cnt_q <= '0;
            end else if (out_valid[k] && out_ready[k]) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign cnt[k*CNT_W +: CNT_W] = cnt_q;
    end
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign cnt            = '0;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Randomized scoreboard bench for stream_demux (N_CH=5, non power of two).
// Counter expectations follow DEMUX_CNT_EN when defined.
module tb_stream_demux;

    localparam int WIDTH = 8;
    localparam int N_CH  = 5;
    localparam int SEL_W = 3;
    localparam int CNT_W = 2;
    localparam int NCYC  = 4096;

`ifdef DEMUX_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [WIDTH-1:0]      in_data = '0;
    logic [SEL_W-1:0]      in_sel = '0;
    logic                  in_last = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [N_CH*WIDTH-1:0] out_data;
    logic [N_CH-1:0]       out_last;
    logic [N_CH-1:0]       out_valid;
    logic [N_CH-1:0]       out_ready = '0;
    logic                  err_drop;
    logic                  cnt_clr = 1'b0;
    logic [N_CH*CNT_W-1:0] cnt;

    always #5 clk = ~clk;

    stream_demux #(
        .WIDTH (WIDTH),
        .N_CH  (N_CH),
        .SEL_W (SEL_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_drop  (err_drop),
        .cnt_clr   (cnt_clr),
        .cnt       (cnt)
    );

    typedef struct {
        int               lane;
        logic [WIDTH-1:0] data;
        logic             last;
    } beat_t;

    int    errors = 0;
    int    checks = 0;
    int    cyc    = 0;
    bit    done   = 1'b0;
    beat_t sbq[$];

    logic [N_CH-1:0]       exp_vld  [NCYC];
    logic                  exp_drop [NCYC];
    logic [N_CH*CNT_W-1:0] exp_cnt  [NCYC];

    bit m_full   = 1'b0;
    int m_lane   = 0;
    bit m_locked = 1'b0;
    int m_lock   = 0;
    int m_cnt [N_CH];
    bit hold     = 1'b0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // One clock of stimulus plus the reference model's view of it.
    task automatic cycle(input logic v, input logic [WIDTH-1:0] d,
                         input logic [SEL_W-1:0] s, input logic l,
                         input logic [N_CH-1:0] o, input logic c,
                         input logic r);
        bit    exp_rdy;
        bit    acc;
        bit    drn;
        bit    drop_next;
        int    eff;
        beat_t b;
        @(negedge clk);
        cyc++;
        if (cyc + 1 >= NCYC) begin
            $display("FAIL cycle_budget cyc=%0d got=over want=under", cyc);
            $fatal(1);
        end
        rst       = r;
        out_ready = o;
        cnt_clr   = c;
        if (!hold) begin
            in_valid = v;
            in_data  = d;
            in_sel   = s;
            in_last  = l;
        end
        #1;
        exp_rdy = !r && (!m_full || o[m_lane]);
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        acc       = in_valid && exp_rdy;
        hold      = in_valid && !acc;
        drop_next = 1'b0;
        if (r) begin
            m_full   = 1'b0;
            m_locked = 1'b0;
            m_lock   = 0;
            for (int k = 0; k < N_CH; k++) m_cnt[k] = 0;
            sbq.delete();
        end else begin
            drn = m_full && o[m_lane];
            if (CNT_ON) begin
                if (c) begin
                    for (int k = 0; k < N_CH; k++) m_cnt[k] = 0;
                end else if (drn) begin
                    m_cnt[m_lane] = (m_cnt[m_lane] + 1) % (1 << CNT_W);
                end
            end
            if (drn) m_full = 1'b0;
            if (acc) begin
                eff = m_locked ? m_lock : int'(in_sel);
                if (eff < N_CH) begin
                    b.lane = eff;
                    b.data = in_data;
                    b.last = in_last;
                    sbq.push_back(b);
                    m_full = 1'b1;
                    m_lane = eff;
                end else begin
                    drop_next = 1'b1;
                end
                if (!m_locked && !in_last) begin
                    m_locked = 1'b1;
                    m_lock   = int'(in_sel);
                end else if (m_locked && in_last) begin
                    m_locked = 1'b0;
                end
            end
        end
        exp_vld[cyc+1]  = m_full ? N_CH'(1 << m_lane) : '0;
        exp_drop[cyc+1] = drop_next;
        for (int k = 0; k < N_CH; k++) begin
            exp_cnt[cyc+1][k*CNT_W +: CNT_W] = CNT_W'(m_cnt[k]);
        end
    endtask

    // Monitor: compares what the DUT presents after each edge.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            #2;
            if (done) break;
            if (cyc >= 2) begin
                check("out_valid", 64'(out_valid), 64'(exp_vld[cyc]));
                check("err_drop", 64'(err_drop), 64'(exp_drop[cyc]));
                check("cnt", 64'(cnt), 64'(exp_cnt[cyc]));
                for (int k = 0; k < N_CH; k++) begin
                    if (!out_valid[k]) begin
                        check("idle_lane",
                              64'({out_last[k], out_data[k*WIDTH +: WIDTH]}),
                              64'(0));
                    end else if (out_ready[k] && !rst) begin
                        if (sbq.size() == 0) begin
                            check("unexpected_beat", 64'(k), 64'(-1));
                        end else begin
                            b = sbq.pop_front();
                            check("lane", 64'(k), 64'(b.lane));
                            check("data", 64'(out_data[k*WIDTH +: WIDTH]),
                                  64'(b.data));
                            check("last", 64'(out_last[k]), 64'(b.last));
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [N_CH-1:0] all1;
        all1 = '1;
        for (int k = 0; k < N_CH; k++) m_cnt[k] = 0;

        cycle(0, 0, 0, 0, '0, 0, 1);
        cycle(0, 0, 0, 0, '0, 0, 1);

        // Single-beat packets to every lane.
        for (int s = 0; s < N_CH; s++) begin
            cycle(1, WIDTH'(8'hA0 + s), SEL_W'(s), 1, all1, 0, 0);
        end
        // Out-of-range selects drop, then normal delivery resumes.
        cycle(1, 8'hE5, 3'd5, 1, all1, 0, 0);
        cycle(1, 8'hE7, 3'd7, 1, all1, 0, 0);
        cycle(1, 8'hB0, 3'd0, 1, all1, 0, 0);

        // Locked packet ignores select changes.
        cycle(1, 8'hC0, 3'd2, 0, all1, 0, 0);
        cycle(1, 8'hC1, 3'd1, 0, all1, 0, 0);
        cycle(1, 8'hC2, 3'd1, 1, all1, 0, 0);

        // Backpressure on lane 1 then drain+accept together.
        cycle(1, 8'hD0, 3'd1, 1, all1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 8'hD1, 3'd0, 1, 5'b11101, 0, 0);
        end
        cycle(1, 8'hD1, 3'd0, 1, all1, 0, 0);
        cycle(0, 0, 0, 0, all1, 0, 0);

        // Reset in the middle of a locked packet.
        cycle(1, 8'h50, 3'd3, 0, all1, 0, 0);
        cycle(1, 8'h51, 3'd3, 0, '0, 0, 0);
        cycle(0, 0, 0, 0, '0, 0, 1);
        cycle(1, 8'h60, 3'd4, 1, all1, 0, 0);
        cycle(0, 0, 0, 0, all1, 0, 0);

        // Counter wrap on lane 0, then clear racing a delivery.
        for (int i = 0; i < 5; i++) begin
            cycle(1, WIDTH'(8'h70 + i), 3'd0, 1, all1, 0, 0);
        end
        cycle(1, 8'h7F, 3'd0, 1, all1, 1, 0);
        cycle(0, 0, 0, 0, all1, 0, 0);
        cycle(0, 0, 0, 0, all1, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            cycle(($urandom % 4) != 0,
                  WIDTH'($urandom),
                  SEL_W'($urandom_range(0, 7)),
                  ($urandom % 3) == 0,
                  N_CH'($urandom) | N_CH'($urandom),
                  ($urandom % 40) == 0,
                  ($urandom % 300) == 0);
        end

        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 0, all1, 0, 0);
        end
        #5;
        check("sb_empty", 64'(sbq.size()), 64'(0));
        done = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
